mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Shares the single request port of memctrl among instruction fetch, load and store requesters.
//  Sits between IF / LSB and memctrl, keeping at most one transaction in flight.
//  Grants by fixed priority with a fetch anti-starvation override.
//  Routes memctrl completion data back to the owner; flush discards speculative fetch/load results.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive lost arbitrations after which a pending fetch wins once
//  CNT_W         3   width of starvation counter (must hold STARVE_LIMIT)
// PORTS
//  clk_in     in   1   clock
//  rst_in     in   1   synchronous reset, active-high
//  rdy_in     in   1   global ready; low = freeze all state
//  clear_in   in   1   flush (mispredict): cancel pending/in-flight fetch and load
//  if_req     in   1   fetch request, held until if_done or clear_in
//  if_addr    in   32  fetch address
//  if_done    out  1   one-cycle fetch completion pulse
//  if_data    out  32  fetched instruction, valid with if_done
//  ld_req     in   1   load request, held until ld_done or clear_in
//  ld_addr    in   32  load address
//  ld_len     in   3   load byte count: 1, 2 or 4
//  ld_done    out  1   one-cycle load completion pulse
//  ld_data    out  32  zero-extended load data, valid with ld_done
//  st_req     in   1   committed store request, held until st_done
//  st_addr    in   32  store address
//  st_data    in   32  store data
//  st_len     in   3   store byte count: 1, 2 or 4
//  st_done    out  1   one-cycle store completion pulse
//  mc_read    out  1   to memctrl: read request, stable until mc_done
//  mc_write   out  1   to memctrl: write request, stable until mc_done
//  mc_addr    out  32  to memctrl: address
//  mc_wdata   out  32  to memctrl: store data
//  mc_len     out  3   to memctrl: byte count (fetch uses 4)
//  mc_done    in   1   from memctrl: transaction complete pulse
//  mc_rdata   in   32  from memctrl: read data, valid with mc_done
// BEHAVIOUR
//  Reset: state=IDLE. mc_read/mc_write/if_done/ld_done/st_done=0.
//   mc_addr/mc_wdata/if_data/ld_data=0. mc_len=0. starve_cnt=0. owner=NONE.
//  rdy_in=0: no register changes, and mc_done is ignored that cycle.
//  States: IDLE -> BUSY -> GAP -> IDLE; DRAIN for a flushed in-flight read.
//  IDLE: select one requester and register the grant. mc_* asserts the next cycle (1-cycle grant latency).
//   Priority: st > ld > if. Exception: starve_cnt==STARVE_LIMIT and if_req -> if wins.
//   starve_cnt: +1 (saturating) when if_req is present but loses; cleared when fetch is granted.
//   clear_in in IDLE: if_req/ld_req are ignored that cycle; a store may still be granted.
//  BUSY: mc_read (if/ld) or mc_write (st) held, with addr/len/wdata constant.
//   On mc_done: owner's done pulse is registered the next cycle.
//    if_data/ld_data <= mc_rdata. mc_read/mc_write drop. Go to GAP.
//   clear_in while owner is if/ld: go to DRAIN with the request held, since memctrl cannot abort.
//   clear_in while owner is st: ignored; the store completes normally.
//  DRAIN: keep request until mc_done, then go to GAP with no done pulse and data discarded.
//  GAP: one idle cycle with no request, letting memctrl counters return to 0. Then go to IDLE.
//  mc_done and clear_in in the same BUSY cycle: clear wins, no done pulse, go to GAP.
//  Done pulses last exactly one cycle. Back-to-back grants are at least 2 cycles after mc_done.
//  mc_read and mc_write are never both 1. A dropped request is never replayed.
// STRUCTURE
//  Shared package/define: state encodings (IDLE, BUSY, DRAIN, GAP) and owner IDs (NONE, IF, LD, ST).
//  Same package: byte-length constants LEN_B=1, LEN_H=2, LEN_W=4.
//  One sub-module: arb_prio_sel, a combinational pick of {st, ld, if} with starve override.
// TESTING
//  1 Fetch alone: if_req, addr 0x100; mc_done at cycle 6 with 0x00A00093.
//    -> mc_read at cycle 1; if_done=1 and if_data=0x00A00093 at cycle 7.
//  2 Simultaneous if_req/ld_req/st_req (st addr 0x20, data 0xDEADBEEF, len 4).
//    -> grant order st, ld, if; mc_write only during the store.
//  3 Starvation: ld_req held continuously with if_req. -> Fetch is granted after 4 lost decisions.
//    -> starve_cnt resets to 0.
//  4 clear_in during a BUSY load (ld_addr 0x40). -> DRAIN; no ld_done when mc_done arrives.
//    -> GAP, then IDLE.
//  5 rdy_in=0 for 3 cycles in BUSY with mc_done pulsed. -> No state change and no done pulse.
//    -> Completion is honoured once mc_done recurs with rdy_in=1.
//  6 rst_in mid-store. -> All outputs 0 the next cycle and state IDLE.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg
//  Shared types and constants for the memctrl request arbiter:
//   arb_state_e : arbiter FSM states (IDLE, BUSY, DRAIN, GAP)
//   owner_e     : owner of the in-flight transaction (NONE, IF, LD, ST)
//   mc_req_t    : registered request presented to memctrl
//   LEN_*       : byte-count encodings used on ld_len/st_len/mc_len
//   zext_len    : zero-extends returned read data to the requested size
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2,
    ARB_GAP   = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2,
    OWN_ST   = 2'd3
  } owner_e;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  len;
  } mc_req_t;

  // memctrl returns the addressed bytes in the low lanes; upper lanes are
  // don't-care for sub-word reads and get cleared here.
  function automatic logic [31:0] zext_len(input logic [31:0] d, input logic [2:0] len);
    logic [31:0] r;
    case (len)
      LEN_B:   r = {24'd0, d[7:0]};
      LEN_H:   r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_prio.sv
// arb_prio_sel
//  Combinational pick of one requester: st > ld > if, except that a pending
//  fetch wins outright once it has been starved to the limit.
//  Ports:
//   if_req/ld_req/st_req in  : qualified requests (flush already applied)
//   starve_hit           in  : starvation counter has reached its limit
//   gnt                  out : selected owner (OWN_NONE if nothing pending)
//   if_lost              out : a fetch was pending but someone else won
module arb_prio_sel
  import mem_req_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   ld_req,
  input  logic   st_req,
  input  logic   starve_hit,
  output owner_e gnt,
  output logic   if_lost
);

  always_comb begin
    gnt = OWN_NONE;
    if (if_req && starve_hit) gnt = OWN_IF;
    else if (st_req)          gnt = OWN_ST;
    else if (ld_req)          gnt = OWN_LD;
    else if (if_req)          gnt = OWN_IF;
    if_lost = if_req && (gnt != OWN_IF);
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//  Shares memctrl's single request port among instruction fetch, load and
//  store. At most one transaction is in flight. Grants are registered, so
//  mc_read/mc_write rise the cycle after the IDLE decision. Completion data
//  is steered back to the owner; a flush cancels fetch/load results, but an
//  issued read cannot be aborted, so it is drained silently.
//  Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (low = freeze all state)
//   clear_in                    : flush of speculative fetch/load
//   if_req/if_addr -> if_done/if_data
//   ld_req/ld_addr/ld_len -> ld_done/ld_data (zero-extended)
//   st_req/st_addr/st_data/st_len -> st_done
//   mc_read/mc_write/mc_addr/mc_wdata/mc_len -> memctrl, mc_done/mc_rdata <- memctrl
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_len,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_len,
  output logic        st_done,
  output logic        mc_read,
  output logic        mc_write,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [2:0]  mc_len,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  mc_req_t          mc_q, mc_d;
  logic             if_done_q, if_done_d;
  logic             ld_done_q, ld_done_d;
  logic             st_done_q, st_done_d;
  logic [31:0]      if_data_q, if_data_d;
  logic [31:0]      ld_data_q, ld_data_d;

  // A flush makes this cycle's fetch/load requests stale; stores are
  // committed and stay eligible.
  logic   if_vld, ld_vld, if_lost;
  owner_e gnt;

  assign if_vld = if_req && !clear_in;
  assign ld_vld = ld_req && !clear_in;

  arb_prio_sel u_prio (
    .if_req     (if_vld),
    .ld_req     (ld_vld),
    .st_req     (st_req),
    .starve_hit (starve_cnt_q == STARVE_MAX),
    .gnt        (gnt),
    .if_lost    (if_lost)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    mc_d         = mc_q;
    if_data_d    = if_data_q;
    ld_data_d    = ld_data_q;
    if_done_d    = 1'b0;
    ld_done_d    = 1'b0;
    st_done_d    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (gnt != OWN_NONE) begin
          state_d = ARB_BUSY;
          owner_d = gnt;
          mc_d.rd = (gnt != OWN_ST);
          mc_d.wr = (gnt == OWN_ST);
          case (gnt)
            OWN_ST: begin
              mc_d.addr  = st_addr;
              mc_d.wdata = st_data;
              mc_d.len   = st_len;
            end
            OWN_LD: begin
              mc_d.addr = ld_addr;
              mc_d.len  = ld_len;
            end
            default: begin
              mc_d.addr = if_addr;
              mc_d.len  = LEN_W;
            end
          endcase
        end
        if (gnt == OWN_IF)
          starve_cnt_d = '0;
        else if (if_lost && starve_cnt_q != STARVE_MAX)
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end

      ARB_BUSY: begin
        if (clear_in && owner_q != OWN_ST) begin
          // Read already issued: memctrl must finish it, result is dropped.
          if (mc_done) begin
            mc_d.rd = 1'b0;
            mc_d.wr = 1'b0;
            owner_d = OWN_NONE;
            state_d = ARB_GAP;
          end else begin
            state_d = ARB_DRAIN;
          end
        end else if (mc_done) begin
          mc_d.rd = 1'b0;
          mc_d.wr = 1'b0;
          owner_d = OWN_NONE;
          state_d = ARB_GAP;
          case (owner_q)
            OWN_IF: begin
              if_done_d = 1'b1;
              if_data_d = mc_rdata;
            end
            OWN_LD: begin
              ld_done_d = 1'b1;
              ld_data_d = zext_len(mc_rdata, mc_q.len);
            end
            OWN_ST:  st_done_d = 1'b1;
            default: ;
          endcase
        end
      end

      ARB_DRAIN: begin
        if (mc_done) begin
          mc_d.rd = 1'b0;
          mc_d.wr = 1'b0;
          owner_d = OWN_NONE;
          state_d = ARB_GAP;
        end
      end

      // One request-free cycle so memctrl's counters settle before the
      // next grant decision.
      ARB_GAP: begin
        owner_d = OWN_NONE;
        state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  // rdy_in low freezes every register, which also masks mc_done.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
      mc_q         <= '0;
      if_done_q    <= 1'b0;
      ld_done_q    <= 1'b0;
      st_done_q    <= 1'b0;
      if_data_q    <= '0;
      ld_data_q    <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      mc_q         <= mc_d;
      if_done_q    <= if_done_d;
      ld_done_q    <= ld_done_d;
      st_done_q    <= st_done_d;
      if_data_q    <= if_data_d;
      ld_data_q    <= ld_data_d;
    end
  end

  assign mc_read  = mc_q.rd;
  assign mc_write = mc_q.wr;
  assign mc_addr  = mc_q.addr;
  assign mc_wdata = mc_q.wdata;
  assign mc_len   = mc_q.len;
  assign if_done  = if_done_q;
  assign ld_done  = ld_done_q;
  assign st_done  = st_done_q;
  assign if_data  = if_data_q;
  assign ld_data  = ld_data_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
//  Table of per-cycle vectors (fetch, flushed load drain, GAP), hand-written
//  sequences for priority, starvation, freeze, store-under-flush and reset,
//  then a randomized run against a transaction-level reference model.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        if_req, ld_req, st_req, mc_done;
  logic [31:0] if_addr, ld_addr, st_addr, st_data, mc_rdata;
  logic [2:0]  ld_len, st_len;
  logic        if_done, ld_done, st_done, mc_read, mc_write;
  logic [31:0] if_data, ld_data, mc_addr, mc_wdata;
  logic [2:0]  mc_len;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  mem_req_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_len(st_len), .st_done(st_done),
    .mc_read(mc_read), .mc_write(mc_write), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_len(mc_len), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    mc_done = 1'b0; mc_rdata = '0;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  // ---------------- per-cycle vector table ----------------
  typedef struct {
    bit          clr, ifr, ldr, mcd;
    logic [31:0] rdata;
    bit          e_rd, e_ifd, e_ldd;
    logic [31:0] e_addr, e_data;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mkv(bit clr, bit ifr, bit ldr, bit mcd, logic [31:0] rdata,
                               bit erd, bit eifd, bit eldd, logic [31:0] eaddr, logic [31:0] edata);
    vec_t v;
    v.clr = clr; v.ifr = ifr; v.ldr = ldr; v.mcd = mcd; v.rdata = rdata;
    v.e_rd = erd; v.e_ifd = eifd; v.e_ldd = eldd; v.e_addr = eaddr; v.e_data = edata;
    return v;
  endfunction

  // Wait for a grant, check it, complete it after a short latency and
  // check the owner's done pulse.
  task automatic serve(input string nm, input bit wr, input logic [31:0] addr,
                       input logic [2:0] len, input logic [31:0] wd, input logic [31:0] rdata,
                       input logic [2:0] done_v, input logic [31:0] edata, input bit drop);
    int n = 0;
    while (!(mc_read || mc_write) && n < 20) begin tick(); n++; end
    chk({nm, " rd_wr"}, {30'd0, mc_read, mc_write}, wr ? 32'd1 : 32'd2);
    chk({nm, " addr"}, mc_addr, addr);
    chk({nm, " len"}, {29'd0, mc_len}, {29'd0, len});
    if (wr) chk({nm, " wdata"}, mc_wdata, wd);
    tick();
    chk({nm, " held"}, {30'd0, mc_read, mc_write}, wr ? 32'd1 : 32'd2);
    mc_done = 1'b1; mc_rdata = rdata;
    tick();
    mc_done = 1'b0;
    chk({nm, " done"}, {29'd0, if_done, ld_done, st_done}, {29'd0, done_v});
    if (done_v[2]) chk({nm, " if_data"}, if_data, edata);
    if (done_v[1]) chk({nm, " ld_data"}, ld_data, edata);
    chk({nm, " drop"}, {30'd0, mc_read, mc_write}, 32'd0);
    if (drop) begin
      if (done_v[2]) if_req = 1'b0;
      if (done_v[1]) ld_req = 1'b0;
      if (done_v[0]) st_req = 1'b0;
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_busy, m_discard, m_cool;
  int          m_who;   // 0 none, 1 fetch, 2 load, 3 store
  int          m_lost;
  logic        e_rd, e_wr, e_ifd, e_ldd, e_std;
  logic [31:0] e_addr, e_wd, e_ifdat, e_lddat;
  logic [2:0]  e_len;

  task automatic model_reset();
    m_busy = 0; m_discard = 0; m_cool = 0; m_who = 0; m_lost = 0;
    e_rd = 0; e_wr = 0; e_ifd = 0; e_ldd = 0; e_std = 0;
    e_addr = '0; e_wd = '0; e_ifdat = '0; e_lddat = '0; e_len = '0;
  endtask

  // Advances the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    bit          iv, lv;
    int          w;
    logic [63:0] mask;
    if (!rdy_in) return;
    e_ifd = 0; e_ldd = 0; e_std = 0;
    if (m_cool) begin
      m_cool = 0;
    end else if (m_busy) begin
      if (clear_in && m_who != 3) m_discard = 1;
      if (mc_done) begin
        m_busy = 0; m_cool = 1; e_rd = 0; e_wr = 0;
        if (!m_discard) begin
          if (m_who == 1) begin e_ifd = 1; e_ifdat = mc_rdata; end
          if (m_who == 2) begin
            mask = (64'd1 << (8 * e_len)) - 64'd1;
            e_ldd = 1; e_lddat = mc_rdata & mask[31:0];
          end
          if (m_who == 3) e_std = 1;
        end
        m_discard = 0;
      end
    end else begin
      iv = if_req && !clear_in;
      lv = ld_req && !clear_in;
      w = 0;
      if (iv && m_lost >= LIMIT) w = 1;
      else if (st_req)           w = 3;
      else if (lv)               w = 2;
      else if (iv)               w = 1;
      if (w == 1) m_lost = 0;
      else if (iv) m_lost = (m_lost + 1 > LIMIT) ? LIMIT : m_lost + 1;
      if (w != 0) begin
        m_busy = 1; m_who = w;
        e_rd = (w != 3); e_wr = (w == 3);
        if (w == 1) begin e_addr = if_addr; e_len = LEN_W; end
        if (w == 2) begin e_addr = ld_addr; e_len = ld_len; end
        if (w == 3) begin e_addr = st_addr; e_len = st_len; e_wd = st_data; end
      end
    end
  endtask

  function automatic logic [2:0] rnd_len();
    int k = $urandom_range(0, 2);
    return (k == 0) ? LEN_B : (k == 1) ? LEN_H : LEN_W;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  n, lat;
    bit  clr_prev;
    if_addr = '0; ld_addr = '0; ld_len = LEN_W;
    st_addr = '0; st_data = '0; st_len = LEN_W;
    do_reset();

    // reset state
    chk1("rst mc_read", mc_read, 1'b0);
    chk1("rst mc_write", mc_write, 1'b0);
    chk("rst mc_addr", mc_addr, 32'd0);
    chk("rst mc_len", {29'd0, mc_len}, 32'd0);
    chk("rst dones", {29'd0, if_done, ld_done, st_done}, 32'd0);
    chk("rst if_data", if_data, 32'd0);

    // fetch alone; flushed load drains silently; GAP ignores requests
    tbl[0]  = mkv(0,1,0,0,32'h0,        1,0,0,32'h100,32'h0);
    tbl[1]  = mkv(0,1,0,0,32'h0,        1,0,0,32'h100,32'h0);
    tbl[2]  = mkv(0,1,0,0,32'h0,        1,0,0,32'h100,32'h0);
    tbl[3]  = mkv(0,1,0,0,32'h0,        1,0,0,32'h100,32'h0);
    tbl[4]  = mkv(0,1,0,0,32'h0,        1,0,0,32'h100,32'h0);
    tbl[5]  = mkv(0,1,0,0,32'h0,        1,0,0,32'h100,32'h0);
    tbl[6]  = mkv(0,1,0,1,32'h00A00093, 0,1,0,32'h0,  32'h00A00093);
    tbl[7]  = mkv(0,0,0,0,32'h0,        0,0,0,32'h0,  32'h0);
    tbl[8]  = mkv(0,0,0,0,32'h0,        0,0,0,32'h0,  32'h0);
    tbl[9]  = mkv(0,0,1,0,32'h0,        1,0,0,32'h40, 32'h0);
    tbl[10] = mkv(1,0,1,0,32'h0,        1,0,0,32'h40, 32'h0);
    tbl[11] = mkv(0,0,0,0,32'h0,        1,0,0,32'h40, 32'h0);
    tbl[12] = mkv(0,0,0,1,32'h12345678, 0,0,0,32'h0,  32'h0);
    tbl[13] = mkv(0,1,0,0,32'h0,        0,0,0,32'h0,  32'h0);
    tbl[14] = mkv(0,1,0,0,32'h0,        1,0,0,32'h100,32'h0);
    tbl[15] = mkv(0,1,0,1,32'h00000011, 0,1,0,32'h0,  32'h00000011);
    tbl[16] = mkv(0,0,0,0,32'h0,        0,0,0,32'h0,  32'h0);
    if_addr = 32'h100; ld_addr = 32'h40; ld_len = LEN_W;
    for (int i = 0; i < 17; i++) begin
      rdy_in = 1'b1; st_req = 1'b0;
      clear_in = tbl[i].clr; if_req = tbl[i].ifr; ld_req = tbl[i].ldr;
      mc_done = tbl[i].mcd; mc_rdata = tbl[i].rdata;
      tick();
      chk($sformatf("vec%0d mc_read", i), {31'd0, mc_read}, {31'd0, tbl[i].e_rd});
      chk($sformatf("vec%0d mc_write", i), {31'd0, mc_write}, 32'd0);
      chk($sformatf("vec%0d if_done", i), {31'd0, if_done}, {31'd0, tbl[i].e_ifd});
      chk($sformatf("vec%0d ld_done", i), {31'd0, ld_done}, {31'd0, tbl[i].e_ldd});
      if (tbl[i].e_rd) begin
        chk($sformatf("vec%0d mc_addr", i), mc_addr, tbl[i].e_addr);
        chk($sformatf("vec%0d mc_len", i), {29'd0, mc_len}, {29'd0, LEN_W});
      end
      if (tbl[i].e_ifd) chk($sformatf("vec%0d if_data", i), if_data, tbl[i].e_data);
    end
    chk("flushed load data discarded", ld_data, 32'd0);

    // simultaneous requests: st, then ld, then if
    do_reset();
    if_req = 1; if_addr = 32'h200;
    ld_req = 1; ld_addr = 32'h44; ld_len = LEN_H;
    st_req = 1; st_addr = 32'h20; st_data = 32'hDEADBEEF; st_len = LEN_W;
    serve("prio st", 1, 32'h20, LEN_W, 32'hDEADBEEF, 32'h0, 3'b001, 32'h0, 1);
    serve("prio ld", 0, 32'h44, LEN_H, 32'h0, 32'hCAFEF00D, 3'b010, 32'h0000F00D, 1);
    serve("prio if", 0, 32'h200, LEN_W, 32'h0, 32'h00000013, 3'b100, 32'h00000013, 1);

    // starvation: fetch wins after 4 lost decisions, twice in a row
    do_reset();
    if_req = 1; if_addr = 32'h300;
    ld_req = 1; ld_addr = 32'h50; ld_len = LEN_W;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4)
        serve($sformatf("starve%0d if", i), 0, 32'h300, LEN_W, 32'h0, 32'hA0 + i, 3'b100, 32'hA0 + i, 0);
      else
        serve($sformatf("starve%0d ld", i), 0, 32'h50, LEN_W, 32'h0, 32'hB0 + i, 3'b010, 32'hB0 + i, 0);
    end
    if_req = 0; ld_req = 0;

    // rdy_in low masks mc_done and freezes state
    do_reset();
    ld_req = 1; ld_addr = 32'h60; ld_len = LEN_B;
    n = 0;
    while (!mc_read && n < 20) begin tick(); n++; end
    chk1("frz granted", mc_read, 1'b1);
    rdy_in = 0; mc_done = 1; mc_rdata = 32'h123456AB;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("frz%0d mc_read", i), mc_read, 1'b1);
      chk1($sformatf("frz%0d ld_done", i), ld_done, 1'b0);
    end
    rdy_in = 1; mc_done = 0;
    tick();
    chk1("frz resume held", mc_read, 1'b1);
    mc_done = 1;
    tick();
    mc_done = 0; ld_req = 0;
    chk1("frz ld_done", ld_done, 1'b1);
    chk("frz ld_data", ld_data, 32'h000000AB);
    chk1("frz mc_read drop", mc_read, 1'b0);
    tick();
    chk1("frz single pulse", ld_done, 1'b0);

    // flush in IDLE still grants the store; flush during store is ignored
    do_reset();
    if_req = 1; if_addr = 32'h500; ld_req = 1; ld_addr = 32'h70; ld_len = LEN_W;
    st_req = 1; st_addr = 32'h90; st_data = 32'h0BADF00D; st_len = LEN_W;
    clear_in = 1;
    tick();
    chk1("clr idle store granted", mc_write, 1'b1);
    chk1("clr idle no read", mc_read, 1'b0);
    if_req = 0; ld_req = 0;
    tick();
    clear_in = 0; mc_done = 1;
    tick();
    mc_done = 0; st_req = 0;
    chk1("clr store st_done", st_done, 1'b1);
    tick(); tick();
    chk1("clr no replay", mc_read, 1'b0);

    // reset mid-store
    do_reset();
    st_req = 1; st_addr = 32'h80; st_data = 32'h55AA; st_len = LEN_H;
    n = 0;
    while (!mc_write && n < 20) begin tick(); n++; end
    chk1("rst6 write", mc_write, 1'b1);
    rst_in = 1;
    tick();
    chk1("rst6 mc_write", mc_write, 1'b0);
    chk("rst6 mc_addr", mc_addr, 32'd0);
    chk("rst6 mc_wdata", mc_wdata, 32'd0);
    chk("rst6 mc_len", {29'd0, mc_len}, 32'd0);
    chk1("rst6 st_done", st_done, 1'b0);
    rst_in = 0; st_req = 0; if_req = 1; if_addr = 32'h400;
    tick();
    chk1("rst6 idle grant", mc_read, 1'b1);
    chk("rst6 idle addr", mc_addr, 32'h400);

    // randomized run against the model
    do_reset();
    model_reset();
    lat = $urandom_range(0, 3);
    clr_prev = 0;
    for (int c = 0; c < 2000; c++) begin
      if (e_ifd || clr_prev) if_req = 0;
      else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (e_ldd || clr_prev) ld_req = 0;
      else if (!ld_req && $urandom_range(0, 3) == 0) begin
        ld_req = 1; ld_addr = $urandom; ld_len = rnd_len();
      end
      if (e_std) st_req = 0;
      else if (!st_req && $urandom_range(0, 5) == 0) begin
        st_req = 1; st_addr = $urandom; st_data = $urandom; st_len = rnd_len();
      end
      rdy_in   = ($urandom_range(0, 5) != 0);
      clear_in = ($urandom_range(0, 11) == 0);
      clr_prev = clear_in;
      mc_rdata = $urandom;
      mc_done  = (e_rd || e_wr) && lat == 0;
      if (rdy_in && (e_rd || e_wr) && lat > 0) lat--;
      model_step();
      if (!(e_rd || e_wr)) lat = $urandom_range(0, 3);
      tick();
      chk1($sformatf("rnd%0d mc_read", c), mc_read, e_rd);
      chk1($sformatf("rnd%0d mc_write", c), mc_write, e_wr);
      chk($sformatf("rnd%0d dones", c), {29'd0, if_done, ld_done, st_done}, {29'd0, e_ifd, e_ldd, e_std});
      if (e_rd || e_wr) begin
        chk($sformatf("rnd%0d mc_addr", c), mc_addr, e_addr);
        chk($sformatf("rnd%0d mc_len", c), {29'd0, mc_len}, {29'd0, e_len});
      end
      if (e_wr) chk($sformatf("rnd%0d mc_wdata", c), mc_wdata, e_wd);
      if (e_ifd) chk($sformatf("rnd%0d if_data", c), if_data, e_ifdat);
      if (e_ldd) chk($sformatf("rnd%0d ld_data", c), ld_data, e_lddat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
